// File: rtl/uart_pkg.sv
// Shared state encodings and frame constants for the UART transceiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every BAUD_DIVISOR clocks.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIVISOR = 27
) (
  input  logic MCLK_IN,
  input  logic RESET_IN,
  output logic TICK
);

  localparam int unsigned CntW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIVISOR - 1);

  logic [CntW-1:0] cnt_q;

  // Count 0..BAUD_DIVISOR-1 and wrap.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign TICK = (cnt_q == CntMax);

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART with 16x oversampling, independent TX/RX and a receive holding register
// backed by a one-entry shadow so the CPU-visible byte never changes mid-read.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIVISOR = 27
) (
  input  logic       MCLK_IN,
  input  logic       RESET_IN,
  input  logic       UART_SEND_TRIGGER_IN,
  input  logic [7:0] UART_SEND_BYTE_IN,
  output logic       UART_SEND_BUSY,
  input  logic       UART_RECEIVE_CAPTURE_IN,
  output logic       UART_RECEIVED,
  output logic [7:0] UART_RECEIVE_BYTE,
  output logic       UART_OVERRUN,
  input  logic       UART_RXD_IN,
  output logic       UART_TXD
);

  localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MidTick  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(
    .BAUD_DIVISOR(BAUD_DIVISOR)
  ) u_baud_tick (
    .MCLK_IN (MCLK_IN),
    .RESET_IN(RESET_IN),
    .TICK    (tick)
  );

  // Synchronisers plus one history flop each for edge detection.
  logic trig_meta_q, trig_sync_q, trig_prev_q;
  logic cap_meta_q, cap_sync_q, cap_prev_q;
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  // Two-flop synchronisers, reset to the idle line levels.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      {trig_meta_q, trig_sync_q, trig_prev_q} <= 3'b000;
      {cap_meta_q, cap_sync_q, cap_prev_q}    <= 3'b000;
      {rxd_meta_q, rxd_sync_q, rxd_prev_q}    <= 3'b111;
    end else begin
      {trig_meta_q, trig_sync_q, trig_prev_q} <= {UART_SEND_TRIGGER_IN, trig_meta_q, trig_sync_q};
      {cap_meta_q, cap_sync_q, cap_prev_q}    <= {UART_RECEIVE_CAPTURE_IN, cap_meta_q, cap_sync_q};
      {rxd_meta_q, rxd_sync_q, rxd_prev_q}    <= {UART_RXD_IN, rxd_meta_q, rxd_sync_q};
    end
  end

  logic trig_rise, cap_fall, rxd_fall;
  assign trig_rise = trig_sync_q & ~trig_prev_q;
  assign cap_fall  = ~cap_sync_q & cap_prev_q;
  assign rxd_fall  = ~rxd_sync_q & rxd_prev_q;

  // ---------------------------------------------------------------- transmitter
  tx_state_e  tx_state_q;
  logic [3:0] tx_tick_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  logic       txd_q, busy_q;

  // TX FSM; busy while still in TxIdle means a frame is waiting for the next tick.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      tx_state_q <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          txd_q <= 1'b1;
          if (!busy_q) begin
            if (trig_rise) begin
              tx_shift_q <= UART_SEND_BYTE_IN;
              busy_q     <= 1'b1;
            end
          end else if (tick) begin
            tx_state_q <= TxStart;
            tx_tick_q  <= '0;
            txd_q      <= 1'b0;
          end
        end
        TxStart: begin
          if (tick) begin
            if (tx_tick_q == LastTick) begin
              tx_state_q <= TxData;
              tx_tick_q  <= '0;
              tx_bit_q   <= '0;
              txd_q      <= tx_shift_q[0];
            end else begin
              tx_tick_q <= tx_tick_q + 1'b1;
            end
          end
        end
        TxData: begin
          if (tick) begin
            if (tx_tick_q == LastTick) begin
              tx_tick_q <= '0;
              if (tx_bit_q == LastBit) begin
                tx_state_q <= TxStop;
                txd_q      <= 1'b1;
              end else begin
                tx_bit_q   <= tx_bit_q + 1'b1;
                tx_shift_q <= tx_shift_q >> 1;
                txd_q      <= tx_shift_q[1];
              end
            end else begin
              tx_tick_q <= tx_tick_q + 1'b1;
            end
          end
        end
        TxStop: begin
          txd_q <= 1'b1;
          if (tick) begin
            if (tx_tick_q == LastTick) begin
              tx_state_q <= TxIdle;
              tx_tick_q  <= '0;
              busy_q     <= 1'b0;
            end else begin
              tx_tick_q <= tx_tick_q + 1'b1;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign UART_TXD       = txd_q;
  assign UART_SEND_BUSY = busy_q;

  // ------------------------------------------------------------------- receiver
  rx_state_e  rx_state_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic       rx_done_q;

  // RX FSM; a low stop bit drops back to idle, and re-arming needs a fresh falling edge.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      rx_state_q <= RxIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rxd_fall) begin
            rx_state_q <= RxStart;
            rx_tick_q  <= '0;
          end
        end
        RxStart: begin
          if (tick) begin
            if (rx_tick_q == MidTick) begin
              rx_tick_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rxd_sync_q ? RxIdle : RxData;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
        end
        RxData: begin
          if (tick) begin
            if (rx_tick_q == LastTick) begin
              rx_tick_q  <= '0;
              rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
              if (rx_bit_q == LastBit) begin
                rx_state_q <= RxStop;
              end else begin
                rx_bit_q <= rx_bit_q + 1'b1;
              end
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
        end
        RxStop: begin
          if (tick) begin
            if (rx_tick_q == LastTick) begin
              rx_tick_q  <= '0;
              rx_state_q <= RxIdle;
              rx_done_q  <= rxd_sync_q;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // ------------------------------------------------------------ holding logic
  logic       received_q, received_d;
  logic       overrun_q, overrun_d;
  logic [7:0] hold_q, hold_d;
  logic       shadow_valid_q, shadow_valid_d;
  logic [7:0] shadow_q, shadow_d;

  // Capture release is applied first so a same-cycle completion sees the freed slot.
  always_comb begin
    received_d     = received_q;
    overrun_d      = overrun_q;
    hold_d         = hold_q;
    shadow_valid_d = shadow_valid_q;
    shadow_d       = shadow_q;
    if (cap_fall) begin
      overrun_d = 1'b0;
      if (shadow_valid_q) begin
        hold_d         = shadow_q;
        received_d     = 1'b1;
        shadow_valid_d = 1'b0;
      end else begin
        received_d = 1'b0;
      end
    end
    if (rx_done_q) begin
      if (cap_sync_q) begin
        if (shadow_valid_d) begin
          overrun_d = 1'b1;
        end else begin
          shadow_d       = rx_shift_q;
          shadow_valid_d = 1'b1;
        end
      end else if (received_d) begin
        overrun_d = 1'b1;
      end else begin
        hold_d     = rx_shift_q;
        received_d = 1'b1;
      end
    end
  end

  // Holding and shadow registers.
  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      received_q     <= 1'b0;
      overrun_q      <= 1'b0;
      hold_q         <= 8'h00;
      shadow_valid_q <= 1'b0;
      shadow_q       <= 8'h00;
    end else begin
      received_q     <= received_d;
      overrun_q      <= overrun_d;
      hold_q         <= hold_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_q       <= shadow_d;
    end
  end

  assign UART_RECEIVED     = received_q;
  assign UART_OVERRUN      = overrun_q;
  assign UART_RECEIVE_BYTE = hold_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomised bench for uart_transceiver at BAUD_DIVISOR=4 (64 clocks per bit).
module tb_uart_transceiver;

  localparam int BitCyc = 64;

  logic       MCLK_IN = 1'b0;
  logic       RESET_IN = 1'b1;
  logic       UART_SEND_TRIGGER_IN = 1'b0;
  logic [7:0] UART_SEND_BYTE_IN = 8'h00;
  logic       UART_SEND_BUSY;
  logic       UART_RECEIVE_CAPTURE_IN = 1'b0;
  logic       UART_RECEIVED;
  logic [7:0] UART_RECEIVE_BYTE;
  logic       UART_OVERRUN;
  logic       UART_RXD_IN = 1'b1;
  logic       UART_TXD;

  uart_transceiver #(
    .BAUD_DIVISOR(4)
  ) dut (
    .MCLK_IN                (MCLK_IN),
    .RESET_IN               (RESET_IN),
    .UART_SEND_TRIGGER_IN   (UART_SEND_TRIGGER_IN),
    .UART_SEND_BYTE_IN      (UART_SEND_BYTE_IN),
    .UART_SEND_BUSY         (UART_SEND_BUSY),
    .UART_RECEIVE_CAPTURE_IN(UART_RECEIVE_CAPTURE_IN),
    .UART_RECEIVED          (UART_RECEIVED),
    .UART_RECEIVE_BYTE      (UART_RECEIVE_BYTE),
    .UART_OVERRUN           (UART_OVERRUN),
    .UART_RXD_IN            (UART_RXD_IN),
    .UART_TXD               (UART_TXD)
  );

  always #5 MCLK_IN = ~MCLK_IN;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge MCLK_IN);
    #1;
  endtask

  // Busy-pulse monitor: frames started and length of the last busy pulse.
  int cycle = 0, busy_rises = 0, busy_rise_cyc = 0, busy_len = 0;
  logic busy_prev = 1'b0;
  always @(posedge MCLK_IN) begin
    cycle <= cycle + 1;
    busy_prev <= UART_SEND_BUSY;
    if (UART_SEND_BUSY && !busy_prev) begin
      busy_rises <= busy_rises + 1;
      busy_rise_cyc <= cycle;
    end
    if (!UART_SEND_BUSY && busy_prev) busy_len <= cycle - busy_rise_cyc;
  end

  // Reference model of the CPU-visible receive state.
  logic       m_recv = 1'b0, m_ovr = 1'b0, m_sv = 1'b0;
  logic [7:0] m_byte = 8'h00, m_shadow = 8'h00;

  task automatic model_reset();
    m_recv = 0; m_ovr = 0; m_sv = 0; m_byte = 8'h00; m_shadow = 8'h00;
  endtask

  task automatic model_complete(input logic [7:0] b, input logic cap_high);
    if (cap_high) begin
      if (m_sv) m_ovr = 1;
      else begin m_shadow = b; m_sv = 1; end
    end else if (m_recv) m_ovr = 1;
    else begin m_byte = b; m_recv = 1; end
  endtask

  task automatic model_cap_fall();
    m_ovr = 0;
    if (m_sv) begin m_byte = m_shadow; m_recv = 1; m_sv = 0; end
    else m_recv = 0;
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_received"}, 32'(UART_RECEIVED), 32'(m_recv));
    check_eq({tag, "_byte"}, 32'(UART_RECEIVE_BYTE), 32'(m_byte));
    check_eq({tag, "_overrun"}, 32'(UART_OVERRUN), 32'(m_ovr));
  endtask

  task automatic capture_pulse();
    UART_RECEIVE_CAPTURE_IN = 1'b1;
    cyc(8);
    UART_RECEIVE_CAPTURE_IN = 1'b0;
    cyc(6);
    model_cap_fall();
  endtask

  // Drive one serial frame onto RXD, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) UART_RXD_IN = 1'b0;
      else if (k == 9) UART_RXD_IN = stop_bit;
      else UART_RXD_IN = b[k-1];
      cyc(BitCyc);
    end
    UART_RXD_IN = 1'b1;
    cyc(8);
  endtask

  // Trigger one transmission and decode TXD at bit mid-points.
  task automatic send_and_check(input logic [7:0] b, input logic retrigger);
    logic [9:0] frame;
    int rises0, waited;
    frame = {1'b1, b, 1'b0};
    rises0 = busy_rises;
    UART_SEND_BYTE_IN = b;
    UART_SEND_TRIGGER_IN = 1'b1;
    waited = 0;
    while (UART_TXD && waited < 300) begin
      cyc(1);
      waited++;
    end
    if (UART_TXD) begin
      check_eq("tx_start_timeout", 32'(waited), 32'd0);
      UART_SEND_TRIGGER_IN = 1'b0;
      return;
    end
    for (int c = 1; c < 10 * BitCyc; c++) begin
      cyc(1);
      if (c == 20) UART_SEND_TRIGGER_IN = 1'b0;
      if (retrigger && c == 100) UART_SEND_TRIGGER_IN = 1'b1;
      if (retrigger && c == 110) UART_SEND_TRIGGER_IN = 1'b0;
      if (c % BitCyc == BitCyc / 2)
        check_eq($sformatf("tx_bit%0d", c / BitCyc), 32'(UART_TXD), 32'(frame[c / BitCyc]));
    end
    waited = 0;
    while (UART_SEND_BUSY && waited < 50) begin
      cyc(1);
      waited++;
    end
    check_eq("tx_busy_drop", 32'(UART_SEND_BUSY), 32'd0);
    cyc(2);
    if (busy_len < 632 || busy_len > 648) check_eq("tx_busy_len", 32'(busy_len), 32'd640);
    else check_eq("tx_busy_len_in_range", 32'(busy_len >= 632 && busy_len <= 648), 32'd1);
    cyc(100);
    check_eq("tx_frame_count", 32'(busy_rises - rises0), 32'd1);
    check_eq("tx_idle_high", 32'(UART_TXD), 32'd1);
  endtask

  logic [7:0] rb, tb_byte;

  initial begin
    cyc(5);
    check_rx("reset");
    check_eq("reset_txd", 32'(UART_TXD), 32'd1);
    check_eq("reset_busy", 32'(UART_SEND_BUSY), 32'd0);
    RESET_IN = 1'b0;
    cyc(10);

    // Transmit: fixed pattern with an ignored retrigger, then random bytes.
    send_and_check(8'hA5, 1'b1);
    for (int i = 0; i < 2; i++) send_and_check(8'($urandom), 1'b0);

    // Receive basic frame and capture.
    send_frame(8'h3C, 1'b1);
    model_complete(8'h3C, 1'b0);
    check_rx("rx_3c");
    capture_pulse();
    check_rx("rx_3c_capt");

    // Overrun: second byte without a capture.
    send_frame(8'h11, 1'b1);
    model_complete(8'h11, 1'b0);
    send_frame(8'h22, 1'b1);
    model_complete(8'h22, 1'b0);
    check_rx("ovr");
    capture_pulse();
    check_rx("ovr_capt");

    // Capture held across a completion.
    send_frame(8'h11, 1'b1);
    model_complete(8'h11, 1'b0);
    UART_RECEIVE_CAPTURE_IN = 1'b1;
    cyc(4);
    send_frame(8'h55, 1'b1);
    model_complete(8'h55, 1'b1);
    check_rx("shadow_hold");
    UART_RECEIVE_CAPTURE_IN = 1'b0;
    cyc(6);
    model_cap_fall();
    check_rx("shadow_move");
    capture_pulse();

    // Low glitch on RXD is not a frame.
    UART_RXD_IN = 1'b0;
    cyc(16);
    UART_RXD_IN = 1'b1;
    cyc(10 * BitCyc);
    check_rx("glitch");

    // Framing error leaves flags untouched.
    send_frame(8'h96, 1'b0);
    cyc(20);
    check_rx("framing");

    // Random receive traffic with random captures.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 1) == 1) capture_pulse();
      send_frame(rb, 1'b1);
      model_complete(rb, 1'b0);
      check_rx($sformatf("rand%0d", i));
    end
    capture_pulse();

    // TX and RX simultaneously.
    rb = 8'($urandom);
    tb_byte = 8'($urandom);
    fork
      send_and_check(tb_byte, 1'b0);
      begin
        send_frame(rb, 1'b1);
        model_complete(rb, 1'b0);
      end
    join
    check_rx("duplex");

    // Reset in the middle of a transmission.
    UART_SEND_BYTE_IN = 8'h00;
    UART_SEND_TRIGGER_IN = 1'b1;
    cyc(200);
    UART_SEND_TRIGGER_IN = 1'b0;
    check_eq("pre_reset_busy", 32'(UART_SEND_BUSY), 32'd1);
    @(posedge MCLK_IN);
    #2 RESET_IN = 1'b1;
    #1;
    check_eq("reset_mid_txd", 32'(UART_TXD), 32'd1);
    check_eq("reset_mid_busy", 32'(UART_SEND_BUSY), 32'd0);
    model_reset();
    cyc(3);
    check_rx("reset_mid");
    RESET_IN = 1'b0;
    cyc(10);
    send_and_check(8'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
